mms_frame_buf: RTL and testbench
================================

# mms_frame_buf

Upstream staging block for the four-input min/max selector. It accepts a serial stream of 8-bit samples with a valid/ready handshake and packs each group of four consecutive samples into a frame. Each frame carries its own min/max select bit. Frames are held in a two-bank ping-pong buffer and presented in parallel (number0..number3, select) to the combinational selector under a second valid/ready handshake, so filling continues while a frame is consumed.

## Interface
- DATA_W, 8, sample width
- FRAME_LEN, 4, samples per frame; fixed at 4, not a free parameter
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  sample present
- in_data  in  DATA_W  sample value
- in_select  in  1  frame mode (1 = min, 0 = max); sampled only with the first sample of a frame
- in_ready  out  1  block can accept a sample this cycle
- frame_valid  out  1  a complete frame is presented
- frame_ready  in  1  downstream consumes the presented frame
- number0..number3  out  DATA_W each  frame samples in arrival order
- select  out  1  select bit captured for the presented frame

## Operation
- Storage: two banks, each holding 4×DATA_W plus 1 select bit.
- State registers:
  - wbank (1b): bank being filled.
  - widx (2b): next slot.
  - rbank (1b): bank presented.
  - count (0..2): number of full banks.
- Accept when in_valid && in_ready:
  - Write in_data to bank[wbank][widx].
  - If widx==0, also write in_select to bank[wbank].sel.
  - widx increments, wrapping from 3 to 0.
- Frame completion: an accept with widx==3. On completion wbank toggles and count increments.
- Consume when frame_valid && frame_ready: rbank toggles and count decrements.
- If completion and consume occur in the same cycle, count is unchanged. Both wbank and rbank still toggle.
- in_ready = (count != 2). It depends only on registered state and never combinationally on frame_ready.
- frame_valid = (count != 0).
- number0..3 and select are a mux of bank[rbank].
- Presented data must not change while frame_valid=1 and frame_ready=0. Writes never target rbank while count != 0, except the bank that has just been freed.
- Partial frames are never presented. A partial fill persists indefinitely until completed.
- in_valid while in_ready=0: the sample is ignored and not stored; the upstream must hold it.
- FSM view, derived from count:
  - EMPTY (count 0) → ONE on completion.
  - ONE → FULL on completion without consume.
  - ONE → EMPTY on consume without completion.
  - FULL (count 2) → ONE on consume.
  - Completion while FULL is impossible because in_ready=0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - count=0, widx=0, wbank=0, rbank=0, all bank contents 0.
  - Outputs: in_ready=1, frame_valid=0, number0..3=0, select=0.
- Latency: frame_valid rises on the clock edge that accepts the 4th sample. The frame is visible in the following cycle (1 cycle).
- Throughput: with frame_ready tied high and in_valid continuous, the block accepts one sample per cycle with no stalls and produces one frame every 4 cycles.
- Backpressure: with frame_ready low, the block accepts exactly 8 samples. in_ready falls after the edge that completes the 2nd frame.
  - in_ready returns to 1 the cycle after the first consume.
  - A sample can be accepted in that same cycle.
- Reset mid-frame or mid-hold discards all buffered data immediately, including partial fills.

## Structure
- Shared package mms_pkg holds:
  - DATA_W and FRAME_LEN constants.
  - A frame struct typedef: 4×DATA_W data plus a sel bit.
  - The count encoding constants EMPTY, ONE, FULL.
- One natural sub-module, mms_frame_bank: a single 4-slot bank with write enable, slot index, select write, and a parallel read port. It is instantiated twice.
- Top level holds the pointers, count, and output mux, targeting roughly 150–250 lines total.

## Test plan
- Reset, then drive samples 10,200,3,77 with in_select=1 and frame_ready=1:
  - frame_valid=1 for one cycle.
  - number0..3 = 10,200,3,77; select=1.
  - in_ready stays 1 throughout.
- frame_ready=0, stream 8 samples 1..8 with select 0 then 1:
  - in_ready=0 after the 8th sample; a 9th sample is not accepted.
  - Frame 1..4 (sel 0) is held stable.
  - After frame_ready pulses, frame 5..8 (sel 1) is presented.
- Simultaneous completion and consume: count stays at 1, frame_valid stays 1, and frames appear in order with no data loss.
- Toggle in_select on samples 2–4 of a frame: the presented select equals the value on sample 1 only.
- Assert reset after 2 samples and again while FULL:
  - All outputs return to reset values on the same edge.
  - The next 4 samples form frame number0..3 in order.
- Randomised in_valid/frame_ready over 1000 samples against a FIFO scoreboard:
  - No drop, duplication, or reorder.
  - No output change while frame_valid && !frame_ready.

Source files
------------

// File: rtl/mms_pkg.sv
// Shared types and constants for the min/max selector frame staging buffer.
// Count encoding tracks how many ping-pong banks hold a complete frame.
package mms_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned IDX_W     = 2;

  typedef logic [DATA_W-1:0] sample_t;

  typedef struct packed {
    sample_t [FRAME_LEN-1:0] data;
    logic                    sel;
  } frame_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_e;

endpackage

// File: rtl/mms_frame_buf_if.sv
// Sample-in and frame-out handshakes of the frame staging buffer.
// master drives samples and consumes frames; slave is the buffer itself.
interface mms_frame_buf_if;
  import mms_pkg::*;

  logic    in_valid;
  sample_t in_data;
  logic    in_select;
  logic    in_ready;
  logic    frame_valid;
  logic    frame_ready;
  sample_t number0;
  sample_t number1;
  sample_t number2;
  sample_t number3;
  logic    select;

  modport master (
    output in_valid, in_data, in_select, frame_ready,
    input  in_ready, frame_valid, number0, number1, number2, number3, select
  );

  modport slave (
    input  in_valid, in_data, in_select, frame_ready,
    output in_ready, frame_valid, number0, number1, number2, number3, select
  );

endinterface

// File: rtl/mms_frame_bank.sv
// One 4-slot frame bank with per-slot write and a parallel read port.
// The select bit is written only together with slot 0.
module mms_frame_bank
  import mms_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  sample_t          wr_data,
  input  logic             wr_sel,
  output frame_t           rd_frame
);

  frame_t frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
    end else if (wr_en) begin
      frame_q.data[wr_idx] <= wr_data;
      if (wr_idx == '0) begin
        frame_q.sel <= wr_sel;
      end
    end
  end

  assign rd_frame = frame_q;

endmodule

// File: rtl/mms_frame_buf.sv
// Ping-pong frame buffer: packs 4 serial samples per frame and presents
// completed frames in parallel while the other bank keeps filling.
module mms_frame_buf
  import mms_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mms_frame_buf_if.slave  bus
);

  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  count_e           count_q, count_d;

  logic   in_ready;
  logic   frame_valid;
  logic   accept;
  logic   complete;
  logic   consume;
  frame_t bank_rd [2];
  frame_t rd_frame;

  // in_ready comes only from registered count, never from frame_ready.
  assign in_ready    = (count_q != FULL);
  assign frame_valid = (count_q != EMPTY);
  assign accept      = bus.in_valid && in_ready;
  assign complete    = accept && (widx_q == IDX_W'(FRAME_LEN - 1));
  assign consume     = frame_valid && bus.frame_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mms_frame_bank u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (accept && (wbank_q == 1'(b))),
      .wr_idx   (widx_q),
      .wr_data  (bus.in_data),
      .wr_sel   (bus.in_select),
      .rd_frame (bank_rd[b])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      widx_q  <= '0;
      count_q <= EMPTY;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      widx_q  <= widx_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    widx_d  = widx_q;
    count_d = count_q;

    if (accept)   widx_d  = widx_q + 1'b1;
    if (complete) wbank_d = ~wbank_q;
    if (consume)  rbank_d = ~rbank_q;

    unique case (count_q)
      EMPTY: if (complete) count_d = ONE;
      ONE: begin
        if (complete && !consume)      count_d = FULL;
        else if (consume && !complete) count_d = EMPTY;
      end
      FULL:    if (consume) count_d = ONE;
      default: count_d = EMPTY;
    endcase
  end

  assign rd_frame        = bank_rd[rbank_q];
  assign bus.in_ready    = in_ready;
  assign bus.frame_valid = frame_valid;
  assign bus.number0     = rd_frame.data[0];
  assign bus.number1     = rd_frame.data[1];
  assign bus.number2     = rd_frame.data[2];
  assign bus.number3     = rd_frame.data[3];
  assign bus.select      = rd_frame.sel;

endmodule

// File: tb/tb_mms_frame_buf.sv
// Bench for mms_frame_buf: directed scenarios plus random traffic, checked
// against a queue-of-frames reference model of the packing rules.
module tb_mms_frame_buf;
  import mms_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mms_frame_buf_if bus ();

  mms_frame_buf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: completed frames as {n0,n1,n2,n3,sel}, plus the partial fill.
  logic [32:0] frames_q [$];
  sample_t     part [4];
  logic        part_sel;
  int          part_n = 0;
  int          accepted = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input sample_t d, input logic s, input logic fr);
    bit acc;
    bit con;
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_select   = s;
    bus.frame_ready = fr;
    #1;
    check("in_ready", bus.in_ready, frames_q.size() != 2);
    check("frame_valid", bus.frame_valid, frames_q.size() != 0);
    if (frames_q.size() != 0)
      check("frame", {bus.number0, bus.number1, bus.number2, bus.number3, bus.select},
            frames_q[0]);
    acc = v && (frames_q.size() != 2);
    con = fr && (frames_q.size() != 0);
    @(posedge clk);
    if (con) void'(frames_q.pop_front());
    if (acc) begin
      if (part_n == 0) part_sel = s;
      part[part_n] = d;
      part_n++;
      accepted++;
      if (part_n == 4) begin
        frames_q.push_back({part[0], part[1], part[2], part[3], part_sel});
        part_n = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.in_valid    = 1'b0;
    bus.frame_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_frame_valid", bus.frame_valid, 0);
    check("rst_outputs", {bus.number0, bus.number1, bus.number2, bus.number3, bus.select}, 0);
    frames_q.delete();
    part_n = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int n_rand;
    int cycles;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_select   = 1'b0;
    bus.frame_ready = 1'b0;
    #2;
    do_reset();

    // Basic frame with frame_ready high.
    step(1'b1, 8'd10,  1'b1, 1'b1);
    step(1'b1, 8'd200, 1'b0, 1'b1);
    step(1'b1, 8'd3,   1'b0, 1'b1);
    step(1'b1, 8'd77,  1'b0, 1'b1);
    step(1'b0, 8'd0,   1'b0, 1'b1);
    step(1'b0, 8'd0,   1'b0, 1'b1);

    // Backpressure: 8 accepted, 9th refused, held frame stable.
    for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), i > 4, 1'b0);
    repeat (3) step(1'b1, 8'd9, 1'b1, 1'b0);
    step(1'b1, 8'd9, 1'b1, 1'b1);
    step(1'b1, 8'd9, 1'b1, 1'b0);
    repeat (2) step(1'b0, 8'd0, 1'b0, 1'b0);
    drain();
    for (int i = 10; i <= 12; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    drain();

    // Completion coincides with consume.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(20 + i), 1'b1, 1'b0);
    step(1'b1, 8'd27, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(30 + i), 1'b0, 1'b1);
    drain();

    // Select captured only on the first sample of a frame.
    step(1'b1, 8'd40, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) step(1'b1, 8'(40 + i), 1'b1, 1'b0);
    step(1'b1, 8'd50, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) step(1'b1, 8'(50 + i), 1'b0, 1'b0);
    drain();

    // Reset mid-frame and while full.
    step(1'b1, 8'd60, 1'b1, 1'b0);
    step(1'b1, 8'd61, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(70 + i), 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(80 + i), 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(90 + i), 1'b1, 1'b1);
    drain();

    // Random traffic.
    n_rand = accepted;
    cycles = 0;
    while ((accepted - n_rand) < 1000 && cycles < 20000) begin
      step(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 5));
      cycles++;
    end
    check("random_accepted", accepted - n_rand, 1000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
